// File: rtl/sap_pkg.sv
// Shared definitions for the SAP-1 style sequencer: opcodes, T-state
// encoding and the control word layout.
package sap_pkg;

    localparam int OP_W_DEF = 4;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // T1 is encoded as 0; the halted state reports 7 on the tstate port.
    typedef enum logic [2:0] {
        T1 = 3'd0, T2 = 3'd1, T3 = 3'd2, T4 = 3'd3,
        T5 = 3'd4, T6 = 3'd5, T7 = 3'd6, T8 = 3'd7
    } tstate_e;

    localparam logic [2:0] TSTATE_HALT = 3'd7;

    // One bit per strobe, MSB first in the order the bus datapath lists them.
    typedef struct packed {
        logic pc_inc;
        logic pc_oe;
        logic mar_load;
        logic ram_oe;
        logic ir_load;
        logic ir_oe;
        logic acc_load;
        logic acc_oe;
        logic alu_sub;
        logic alu_oe;
        logic breg_load;
        logic out_load;
    } ctrl_word_t;

endpackage

// File: rtl/sap_ctrl_decode.sv
// Combinational control-word decode from (T-state, opcode). No gating here;
// the sequencer masks the word when frozen, halted or in reset.
module sap_ctrl_decode
    import sap_pkg::*;
#(
    parameter int OP_W = 4
) (
    input  tstate_e           tstate,
    input  logic [OP_W-1:0]   opcode,
    output ctrl_word_t        ctrl
);

    localparam logic [OP_W-1:0] LDA = OP_W'(OP_LDA);
    localparam logic [OP_W-1:0] ADD = OP_W'(OP_ADD);
    localparam logic [OP_W-1:0] SUB = OP_W'(OP_SUB);
    localparam logic [OP_W-1:0] OUT = OP_W'(OP_OUT);

    logic is_arith;
    assign is_arith = (opcode == ADD) || (opcode == SUB);

    // Fetch is opcode independent; execute states pick strobes by opcode.
    always_comb begin
        ctrl = '0;
        case (tstate)
            T1: begin
                ctrl.pc_oe    = 1'b1;
                ctrl.mar_load = 1'b1;
            end
            T2: ctrl.pc_inc = 1'b1;
            T3: begin
                ctrl.ram_oe  = 1'b1;
                ctrl.ir_load = 1'b1;
            end
            T4: begin
                if (opcode == LDA || is_arith) begin
                    ctrl.ir_oe    = 1'b1;
                    ctrl.mar_load = 1'b1;
                end else if (opcode == OUT) begin
                    ctrl.acc_oe   = 1'b1;
                    ctrl.out_load = 1'b1;
                end
            end
            T5: begin
                if (opcode == LDA) begin
                    ctrl.ram_oe   = 1'b1;
                    ctrl.acc_load = 1'b1;
                end else if (is_arith) begin
                    ctrl.ram_oe    = 1'b1;
                    ctrl.breg_load = 1'b1;
                    ctrl.alu_sub   = (opcode == SUB);
                end
            end
            T6: begin
                if (is_arith) begin
                    ctrl.alu_oe   = 1'b1;
                    ctrl.acc_load = 1'b1;
                    ctrl.alu_sub  = (opcode == SUB);
                end
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/sap_sequencer.sv
// T-state sequencer for the 8-bit bus computer. Holds the T counter and the
// HALT flag; strobes come from sap_ctrl_decode and are masked unless the
// machine advances this cycle. Build option SAP_SEQ_EARLY_RET_EN returns to
// T1 right after the last active T-state of each opcode.
module sap_sequencer
    import sap_pkg::*;
#(
    parameter int T_STATES = 6,
    parameter int OP_W     = 4
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            run,
    input  logic            step,
    input  logic [OP_W-1:0] opcode,
    output logic            pc_inc,
    output logic            pc_oe,
    output logic            mar_load,
    output logic            ram_oe,
    output logic            ir_load,
    output logic            ir_oe,
    output logic            acc_load,
    output logic            acc_oe,
    output logic            alu_sub,
    output logic            alu_oe,
    output logic            breg_load,
    output logic            out_load,
    output logic [2:0]      tstate,
    output logic            halted
);

    localparam logic [OP_W-1:0] HLT = OP_W'(OP_HLT);

    tstate_e    tstate_q, tstate_d;
    logic       halted_q, halted_d;
    tstate_e    ret_t;
    logic       adv;
    ctrl_word_t ctrl_dec, ctrl;

    assign adv = run | step;

`ifdef SAP_SEQ_EARLY_RET_EN
    localparam logic [OP_W-1:0] LDA = OP_W'(OP_LDA);
    localparam logic [OP_W-1:0] ADD = OP_W'(OP_ADD);
    localparam logic [OP_W-1:0] SUB = OP_W'(OP_SUB);
    localparam logic [OP_W-1:0] OUT = OP_W'(OP_OUT);

    // Last active T-state per opcode; NOP-class opcodes end with the fetch.
    always_comb begin
        if (opcode == ADD || opcode == SUB)      ret_t = T6;
        else if (opcode == LDA)                  ret_t = T5;
        else if (opcode == OUT || opcode == HLT) ret_t = T4;
        else                                     ret_t = T3;
    end
`else
    assign ret_t = tstate_e'(T_STATES - 1);
`endif

    // Next-state: advance on run/step, wrap after the return state, HLT latches.
    always_comb begin
        tstate_d = tstate_q;
        halted_d = halted_q;
        if (!halted_q && adv) begin
            if (tstate_q == T4 && opcode == HLT)
                halted_d = 1'b1;
            else if (tstate_q >= ret_t)
                tstate_d = T1;
            else
                tstate_d = tstate_e'(tstate_q + 3'd1);
        end
    end

    // State registers with synchronous reset back to T1 fetch.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            tstate_q <= T1;
            halted_q <= 1'b0;
        end else begin
            tstate_q <= tstate_d;
            halted_q <= halted_d;
        end
    end

    sap_ctrl_decode #(.OP_W(OP_W)) u_decode (
        .tstate (tstate_q),
        .opcode (opcode),
        .ctrl   (ctrl_dec)
    );

    // Strobes only fire in a cycle that actually advances the machine.
    assign ctrl = (adv && !RESET && !halted_q) ? ctrl_dec : '0;

    assign pc_inc    = ctrl.pc_inc;
    assign pc_oe     = ctrl.pc_oe;
    assign mar_load  = ctrl.mar_load;
    assign ram_oe    = ctrl.ram_oe;
    assign ir_load   = ctrl.ir_load;
    assign ir_oe     = ctrl.ir_oe;
    assign acc_load  = ctrl.acc_load;
    assign acc_oe    = ctrl.acc_oe;
    assign alu_sub   = ctrl.alu_sub;
    assign alu_oe    = ctrl.alu_oe;
    assign breg_load = ctrl.breg_load;
    assign out_load  = ctrl.out_load;

    assign tstate = RESET    ? 3'd0        :
                    halted_q ? TSTATE_HALT : 3'(tstate_q);
    assign halted = halted_q & ~RESET;

endmodule

// File: tb/tb_sap_sequencer.sv
// Scoreboard bench for sap_sequencer: each driven cycle pushes the expected
// strobes/tstate/halted, popped and compared on the following falling edge.
module tb_sap_sequencer;
    import sap_pkg::*;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       run = 1'b0;
    logic       step = 1'b0;
    logic [3:0] opcode = 4'b0;
    logic pc_inc, pc_oe, mar_load, ram_oe, ir_load, ir_oe;
    logic acc_load, acc_oe, alu_sub, alu_oe, breg_load, out_load;
    logic [2:0] tstate;
    logic       halted;

    sap_sequencer dut (
        .CLK(CLK), .RESET(RESET), .run(run), .step(step), .opcode(opcode),
        .pc_inc(pc_inc), .pc_oe(pc_oe), .mar_load(mar_load), .ram_oe(ram_oe),
        .ir_load(ir_load), .ir_oe(ir_oe), .acc_load(acc_load), .acc_oe(acc_oe),
        .alu_sub(alu_sub), .alu_oe(alu_oe), .breg_load(breg_load),
        .out_load(out_load), .tstate(tstate), .halted(halted)
    );

    always #5 CLK = ~CLK;

    localparam logic [11:0] S_PC_INC    = 12'h800;
    localparam logic [11:0] S_PC_OE     = 12'h400;
    localparam logic [11:0] S_MAR_LOAD  = 12'h200;
    localparam logic [11:0] S_RAM_OE    = 12'h100;
    localparam logic [11:0] S_IR_LOAD   = 12'h080;
    localparam logic [11:0] S_IR_OE     = 12'h040;
    localparam logic [11:0] S_ACC_LOAD  = 12'h020;
    localparam logic [11:0] S_ACC_OE    = 12'h010;
    localparam logic [11:0] S_ALU_SUB   = 12'h008;
    localparam logic [11:0] S_ALU_OE    = 12'h004;
    localparam logic [11:0] S_BREG_LOAD = 12'h002;
    localparam logic [11:0] S_OUT_LOAD  = 12'h001;
    localparam logic [11:0] F1 = S_PC_OE | S_MAR_LOAD;
    localparam logic [11:0] F2 = S_PC_INC;
    localparam logic [11:0] F3 = S_RAM_OE | S_IR_LOAD;
    localparam logic [3:0]  OP_NOP = 4'b0101;

    typedef struct packed {
        logic [2:0]  t;
        logic        h;
        logic [11:0] s;
    } exp_t;

    exp_t sb_q[$];
    exp_t e_pop;
    int   checks = 0;
    int   errors = 0;

    wire [11:0] strobes = {pc_inc, pc_oe, mar_load, ram_oe, ir_load, ir_oe,
                           acc_load, acc_oe, alu_sub, alu_oe, breg_load, out_load};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h want %0h", tag, $time, obs, exp);
        end
    endtask

    // Pop one expectation per cycle, away from the active edge.
    always @(negedge CLK) begin
        if (sb_q.size() > 0) begin
            e_pop = sb_q.pop_front();
            chk("strobes", 32'(strobes), 32'(e_pop.s));
            chk("tstate", 32'(tstate), 32'(e_pop.t));
            chk("halted", 32'(halted), 32'(e_pop.h));
            chk("bus_oe_excl", 32'($countones({pc_oe, ram_oe, ir_oe, acc_oe, alu_oe}) <= 1), 32'd1);
        end
    end

    task automatic cyc(input logic rst, input logic r, input logic s, input logic [3:0] op,
                       input logic [2:0] et, input logic eh, input logic [11:0] es);
        exp_t e;
        @(posedge CLK);
        #1;
        RESET  = rst;
        run    = r;
        step   = s;
        opcode = op;
        e.t = et;
        e.h = eh;
        e.s = es;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, OP_NOP, 3'd0, 1'b0, 12'h000);
    endtask

    task automatic fetch(input logic [3:0] op);
        cyc(1'b0, 1'b1, 1'b0, op, 3'd0, 1'b0, F1);
        cyc(1'b0, 1'b1, 1'b0, op, 3'd1, 1'b0, F2);
        cyc(1'b0, 1'b1, 1'b0, op, 3'd2, 1'b0, F3);
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        do_reset();

        // LDA: full cycle then back at T1
        fetch(OP_LDA);
        cyc(0, 1, 0, OP_LDA, 3'd3, 0, S_IR_OE | S_MAR_LOAD);
        cyc(0, 1, 0, OP_LDA, 3'd4, 0, S_RAM_OE | S_ACC_LOAD);
`ifndef SAP_SEQ_EARLY_RET_EN
        cyc(0, 1, 0, OP_LDA, 3'd5, 0, 12'h000);
`endif
        cyc(0, 1, 0, OP_LDA, 3'd0, 0, F1);
        do_reset();

        // SUB, with opcode churn during fetch that must not matter
        cyc(0, 1, 0, 4'b0111, 3'd0, 0, F1);
        cyc(0, 1, 0, OP_HLT,  3'd1, 0, F2);
        cyc(0, 1, 0, OP_SUB,  3'd2, 0, F3);
        cyc(0, 1, 0, OP_SUB,  3'd3, 0, S_IR_OE | S_MAR_LOAD);
        cyc(0, 1, 0, OP_SUB,  3'd4, 0, S_RAM_OE | S_BREG_LOAD | S_ALU_SUB);
        cyc(0, 1, 0, OP_SUB,  3'd5, 0, S_ALU_OE | S_ACC_LOAD | S_ALU_SUB);
        cyc(0, 1, 0, OP_SUB,  3'd0, 0, F1);
        do_reset();

        // HLT: sticky through run and step, only RESET exits
        fetch(OP_HLT);
        cyc(0, 1, 0, OP_HLT, 3'd3, 0, 12'h000);
        for (int i = 0; i < 20; i++)
            cyc(0, 1, 1'(i % 2), OP_HLT, 3'd7, 1, 12'h000);
        cyc(1, 1, 1, OP_HLT, 3'd0, 0, 12'h000);
        cyc(0, 0, 0, OP_LDA, 3'd0, 0, 12'h000);

        // Freeze at T3, single-step through
        cyc(0, 1, 0, OP_LDA, 3'd0, 0, F1);
        cyc(0, 1, 0, OP_LDA, 3'd1, 0, F2);
        cyc(0, 0, 0, OP_LDA, 3'd2, 0, 12'h000);
        cyc(0, 0, 0, OP_LDA, 3'd2, 0, 12'h000);
        cyc(0, 0, 1, OP_LDA, 3'd2, 0, F3);
        cyc(0, 0, 0, OP_LDA, 3'd3, 0, 12'h000);
        cyc(0, 0, 1, OP_LDA, 3'd3, 0, S_IR_OE | S_MAR_LOAD);
        cyc(0, 0, 0, OP_LDA, 3'd4, 0, 12'h000);
        do_reset();

        // RESET in T5 of ADD aborts before breg/acc writes
        fetch(OP_ADD);
        cyc(0, 1, 0, OP_ADD, 3'd3, 0, S_IR_OE | S_MAR_LOAD);
        cyc(1, 1, 0, OP_ADD, 3'd0, 0, 12'h000);
        cyc(0, 1, 0, OP_ADD, 3'd0, 0, F1);
        cyc(0, 1, 0, OP_ADD, 3'd1, 0, F2);
        // RESET wins over step
        cyc(1, 0, 1, OP_ADD, 3'd0, 0, 12'h000);
        cyc(0, 0, 0, OP_ADD, 3'd0, 0, 12'h000);
        do_reset();

        // OUT: 4-cycle period with early return, 6 otherwise
        fetch(OP_OUT);
        cyc(0, 1, 0, OP_OUT, 3'd3, 0, S_ACC_OE | S_OUT_LOAD);
`ifndef SAP_SEQ_EARLY_RET_EN
        cyc(0, 1, 0, OP_OUT, 3'd4, 0, 12'h000);
        cyc(0, 1, 0, OP_OUT, 3'd5, 0, 12'h000);
`endif
        fetch(OP_OUT);
        cyc(0, 1, 0, OP_OUT, 3'd3, 0, S_ACC_OE | S_OUT_LOAD);
        do_reset();

        // NOP-class opcode: no execute strobes
        fetch(OP_NOP);
`ifndef SAP_SEQ_EARLY_RET_EN
        cyc(0, 1, 0, OP_NOP, 3'd3, 0, 12'h000);
        cyc(0, 1, 0, OP_NOP, 3'd4, 0, 12'h000);
        cyc(0, 1, 0, OP_NOP, 3'd5, 0, 12'h000);
`endif
        cyc(0, 1, 0, OP_NOP, 3'd0, 0, F1);
        do_reset();

        @(posedge CLK);
        @(negedge CLK);
        #1;
        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
